button_stepper: RTL
===================

# button_stepper

- Converts two bouncy push-buttons (count up, count down) into a clean one-cycle `step` pulse plus a registered `up` direction level.
- Sits directly upstream of the BCD up/down counter: `step` drives the counter's count enable and `up` drives its direction input.
- Provides synchronisation, debounce, single-button arbitration and hold-to-repeat.

## Interface

- DEBOUNCE, 16: sampled edges a synchronised input must be stable at a new level before its debounced level changes. Legal range 2..65535.
- REPEAT_DELAY, 64: cycles from the initial step to the first auto-repeat step while the button is held. Legal range 2..65535.
- REPEAT_PERIOD, 16: cycles between subsequent auto-repeat steps. Legal range 2..65535.
- Internal timers are 16 bits wide, fixed.

Ports:

- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low. Low clears all state immediately; release is synchronous to `clock` by the upstream system.
- btn_up  in  1  raw up button, active-high, asynchronous, may bounce.
- btn_down  in  1  raw down button, active-high, asynchronous, may bounce.
- step  out  1  one-cycle count-enable pulse, registered.
- up  out  1  direction of the most recent step: 1 = up, 0 = down. Registered; holds between steps.
- up_db  out  1  debounced btn_up level, registered.
- down_db  out  1  debounced btn_down level, registered.

## Operation

**Reset values**
- step=0, up=1, up_db=0, down_db=0.
- FSM=IDLE; all synchroniser flops, debounce counters and timers 0.

**Synchroniser**
- Each raw button passes through a 2-flop synchroniser.

**Debounce (per button)**
- Counter clears whenever the synchronised level equals the debounced level.
- Otherwise it increments.
- When it reaches DEBOUNCE, the debounced level toggles and the counter clears on the same edge.
- Any glitch shorter than DEBOUNCE cycles is absorbed.

**Press event**
- A debounced rising edge on either button (registered edge detect on up_db/down_db).

**FSM: IDLE, DELAY, REPEAT, LOCK**
- IDLE:
  - Press event on exactly one button: step=1 next cycle, `up` set to that button's direction, timer=0, go to DELAY.
  - Press events on both buttons in the same cycle: go to LOCK, no step.
- DELAY:
  - Active button debounced low: go to IDLE.
  - Other button debounced high: go to LOCK.
  - Timer reaches REPEAT_DELAY-1: emit step, timer=0, go to REPEAT.
  - Otherwise timer increments.
- REPEAT:
  - Same exit rules as DELAY.
  - Emits a step each time the timer reaches REPEAT_PERIOD-1, then clears the timer.
- LOCK:
  - No steps.
  - Go to IDLE only when up_db=0 and down_db=0.
  - A button still held on leaving LOCK is impossible by construction; a fresh press is required.

**Exit priority**
- Release beats repeat step: no step is emitted in the cycle the FSM leaves DELAY/REPEAT.
- Other-button press beats repeat step.

**Output rules**
- `step` is never high on two consecutive cycles.
- `up` changes only in the same cycle `step` rises.

**Reset mid-operation**
- All outputs return to reset values asynchronously; any in-flight step is dropped.
- A button held through reset release produces a fresh press event after synchroniser + DEBOUNCE latency, and therefore one step.

## Timing

- Let E0 = the first rising edge that samples a raw button high, with the input clean thereafter.
- Synchronised level is high after E0+1.
- Debounced level is high after E0+DEBOUNCE+1.
- `step` is high for exactly the cycle after edge E0+DEBOUNCE+2. Press latency is DEBOUNCE+3 edges.
- Release latency to debounced low: DEBOUNCE+2 edges.
- Auto-repeat, measured from the initial step:
  - First repeat step occurs REPEAT_DELAY cycles later.
  - Subsequent repeat steps are spaced REPEAT_PERIOD cycles apart.
- Throughput: at most one step per 2 cycles; steps are guaranteed by the legal parameter minimum of 2.

## Test plan

(All scenarios use DEBOUNCE=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.)

1. Reset low, then released -> step=0, up=1, up_db=0, down_db=0. Hold btn_down=1 clean from E0 for 6 cycles, then release -> single step pulse in the cycle after edge E0+6, up=0, no further steps.
2. btn_up bounces 1/0/1/0 at 1-cycle intervals, then stays high -> exactly one step, timed DEBOUNCE+3 edges after the last transition to 1.
3. Hold btn_up for 30 cycles -> steps at T, T+8, T+11, T+14, …; all with up=1; steps stop within DEBOUNCE+2 edges of release.
4. Assert btn_up and btn_down raw on the same edge -> no step, FSM in LOCK. Release both, then press btn_down alone -> one step with up=0.
5. Hold btn_up; after its initial step, press btn_down -> no further steps until both are released. The step count equals 1 (or 1 plus any repeats that elapsed before down_db rose).
6. Pull reset low during REPEAT while btn_up is held -> step=0 and up=1 immediately. After reset release, exactly one step occurs 7 edges later.

Source files
------------

// File: rtl/button_stepper.sv
// -----------------------------------------------------------------------------
// button_stepper
//
// Turns two raw, bouncy push-buttons (count up / count down) into a clean
// one-cycle `step` pulse and a registered `up` direction level, intended to
// drive the count-enable and direction inputs of a BCD up/down counter.
// Each button is synchronised (2 flops) and debounced.
// A small FSM then handles:
//   - single-button arbitration
//   - the initial step
//   - hold-to-repeat (first repeat after REPEAT_DELAY, then every REPEAT_PERIOD)
//   - lock-out when both buttons are pressed
//
// Ports
//   clock    in  : single clock, rising edge
//   reset    in  : asynchronous active-low reset
//   btn_up   in  : raw up button, active-high, asynchronous
//   btn_down in  : raw down button, active-high, asynchronous
//   step     out : one-cycle count-enable pulse (registered)
//   up       out : direction of most recent step, 1 = up (registered)
//   up_db    out : debounced btn_up level (registered)
//   down_db  out : debounced btn_down level (registered)
// -----------------------------------------------------------------------------
module button_stepper #(
  parameter int DEBOUNCE      = 16,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic step,
  output logic up,
  output logic up_db,
  output logic down_db
);

  // Terminal counts for the 16-bit counters/timers.
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE - 1);
  localparam logic [15:0] RD_LAST = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] RP_LAST = 16'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2,
    S_LOCK   = 2'd3
  } state_t;

  // Channel 0 = up button, channel 1 = down button.
  logic [1:0] w_btn_raw;
  logic [1:0] w_db;
  logic [1:0] w_press;

  assign w_btn_raw = {btn_down, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic        r_sync1;
      logic        r_sync2;
      logic        r_db;
      logic        r_db_d;
      logic [15:0] r_cnt;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
          r_db    <= 1'b0;
          r_db_d  <= 1'b0;
          r_cnt   <= '0;
        end else begin
          r_sync1 <= w_btn_raw[gi];
          r_sync2 <= r_sync1;
          r_db_d  <= r_db;
          // The counter measures how long the synchronised level has
          // disagreed with the debounced level; any agreement restarts it.
          // Toggling when the count is DEBOUNCE-1 makes this edge the
          // DEBOUNCE-th consecutive disagreeing sample.
          if (r_sync2 == r_db) begin
            r_cnt <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_cnt <= '0;
            r_db  <= ~r_db;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
      end

      assign w_db[gi]    = r_db;
      assign w_press[gi] = r_db & ~r_db_d;
    end
  endgenerate

  state_t      r_state;
  logic [15:0] r_timer;
  logic        r_step;
  logic        r_up;

  // While DELAY/REPEAT is active, r_up also identifies the active button.
  logic        w_active_db;
  logic        w_other_db;
  logic [15:0] w_limit;

  assign w_active_db = r_up ? w_db[0] : w_db[1];
  assign w_other_db  = r_up ? w_db[1] : w_db[0];
  assign w_limit     = (r_state == S_DELAY) ? RD_LAST : RP_LAST;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_step  <= 1'b0;
      r_up    <= 1'b1;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_press[0] && w_press[1]) begin
            r_state <= S_LOCK;
          end else if (w_press[0] || w_press[1]) begin
            r_step  <= 1'b1;
            r_up    <= w_press[0];
            r_timer <= '0;
            r_state <= S_DELAY;
          end
        end
        S_DELAY, S_REPEAT: begin
          // Release and other-button press both take priority over a
          // repeat step that would fall due on the same edge.
          if (!w_active_db) begin
            r_state <= S_IDLE;
          end else if (w_other_db) begin
            r_state <= S_LOCK;
          end else if (r_timer == w_limit) begin
            r_step  <= 1'b1;
            r_timer <= '0;
            r_state <= S_REPEAT;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        S_LOCK: begin
          // Leave only once both buttons are released, so a fresh press
          // (and hence a fresh edge) is needed to step again.
          if (!w_db[0] && !w_db[1]) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign step    = r_step;
  assign up      = r_up;
  assign up_db   = w_db[0];
  assign down_db = w_db[1];

endmodule
